// File: rtl/mul_div_unit_if.sv
// Handshake/bus bundle between the execute stage and the MIPS LO/HI multiply/divide unit.
// Latency: none; it only carries signals.
// Backpressure: `busy` tells the pipeline to stall MFLO/MFHI/MULT/DIV.
//
// Ports (master = execute stage, slave = mul_div_unit):
//   start, op, a, b       request pulse, opcode (0 MULT, 1 MULTU, 2 DIV, 3 DIVU), operands
//   mtlo, mthi, wdata     direct LO/HI writes
//   busy, done, lo, hi    status and the LO/HI registers
interface mul_div_unit_if #(
  parameter int DATA_BITS = 32
);
  logic                 start;
  logic [1:0]           op;
  logic [DATA_BITS-1:0] a;
  logic [DATA_BITS-1:0] b;
  logic                 mtlo;
  logic                 mthi;
  logic [DATA_BITS-1:0] wdata;
  logic                 busy;
  logic                 done;
  logic [DATA_BITS-1:0] lo;
  logic [DATA_BITS-1:0] hi;

  modport master (
    output start, op, a, b, mtlo, mthi, wdata,
    input  busy, done, lo, hi
  );

  modport slave (
    input  start, op, a, b, mtlo, mthi, wdata,
    output busy, done, lo, hi
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit that owns the MIPS LO/HI registers.
// Latency: 33 cycles from the start edge to the LO/HI write; 1 cycle for divide-by-zero
//          (and for multiplies when MULDIV_FAST_MULT_EN is defined).
// Backpressure: `busy` is high while an operation is in flight; start and MT writes are ignored then.
//
// Ports: clk, rst (synchronous, active-high); bus (mul_div_unit_if.slave):
//   start/op/a/b request, mtlo/mthi/wdata direct writes, busy/done/lo/hi registered outputs.
// Optional feature: define MULDIV_FAST_MULT_EN for a single-cycle 64-bit multiply.
module mul_div_unit #(
  parameter int DATA_BITS = 32
) (
  input  logic            clk,
  input  logic            rst,
  mul_div_unit_if.slave   bus
);
  localparam int W = DATA_BITS;

  typedef enum logic [1:0] {IDLE, RUN, SIGN} state_t;

  state_t           state;
  state_t           state_n;

  logic [1:0]       op_q;
  logic [W-1:0]     opa;       // multiplicand magnitude, or raw dividend on the quick path
  logic [W-1:0]     opb;       // divisor magnitude
  logic [2*W-1:0]   acc;       // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic             rsign;
  logic             msign;
  logic             quick;     // result computed without RUN (divide-by-zero / fast multiply)
  logic [5:0]       cnt;

  logic [W-1:0]     lo_q;
  logic [W-1:0]     hi_q;
  logic             busy_q;
  logic             done_q;

  logic             signed_op;
  logic             start_dz;
  logic             start_fast;
  logic [W-1:0]     a_mag;
  logic [W-1:0]     b_mag;
  logic [W:0]       mul_sum;
  logic [2*W-1:0]   mul_step;
  logic [W:0]       rem_sh;
  logic             rem_ge;
  logic [2*W-1:0]   div_step;
  logic [2*W-1:0]   res;

  assign bus.lo   = lo_q;
  assign bus.hi   = hi_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  // Request decode (only meaningful in IDLE with start high).
  assign signed_op = ~bus.op[0];
  assign start_dz  = bus.op[1] && (bus.b == '0);
`ifdef MULDIV_FAST_MULT_EN
  assign start_fast = ~bus.op[1];
`else
  assign start_fast = 1'b0;
`endif
  assign a_mag = (signed_op && bus.a[W-1]) ? -bus.a : bus.a;
  assign b_mag = (signed_op && bus.b[W-1]) ? -bus.b : bus.b;

  // Shift-add step: add multiplicand when the current multiplier LSB is set, then shift right.
  assign mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opa} : '0);
  assign mul_step = {mul_sum, acc[W-1:1]};

  // Restoring division step: 33-bit trial against the divisor. When the trial succeeds the true
  // difference is below the divisor, so the low 32 bits of the subtraction are exact.
  assign rem_sh   = {acc[2*W-1:W], acc[W-1]};
  assign rem_ge   = rem_sh >= {1'b0, opb};
  assign div_step = rem_ge ? {rem_sh[W-1:0] - opb, acc[W-2:0], 1'b1}
                           : {rem_sh[W-1:0], acc[W-2:0], 1'b0};

  // Final LO/HI value written in SIGN.
  always_comb begin
    res = acc;
    if (op_q[1]) begin
      if (quick) begin
        res = {opa, {W{1'b1}}};
      end else begin
        res[W-1:0]   = rsign ? -acc[W-1:0]   : acc[W-1:0];
        res[2*W-1:W] = msign ? -acc[2*W-1:W] : acc[2*W-1:W];
      end
    end else begin
`ifdef MULDIV_FAST_MULT_EN
      if (op_q[0]) begin
        res = {{W{1'b0}}, opa} * {{W{1'b0}}, opb};
      end else begin
        res = $signed({{W{opa[W-1]}}, opa}) * $signed({{W{opb[W-1]}}, opb});
      end
`else
      if (rsign) begin
        res = -acc;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = (start_dz || start_fast) ? SIGN : RUN;
        end
      end
      RUN: begin
        if (cnt == 6'd31) begin
          state_n = SIGN;
        end
      end
      SIGN:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q   <= '0;
      hi_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      op_q   <= '0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      rsign  <= 1'b0;
      msign  <= 1'b0;
      quick  <= 1'b0;
      cnt    <= '0;
    end else begin
      // busy covers RUN and the SIGN cycle that follows it, never the quick path.
      busy_q <= (state_n == RUN) || (state == RUN);
      done_q <= (state == SIGN);
      case (state)
        IDLE: begin
          if (bus.mtlo) lo_q <= bus.wdata;
          if (bus.mthi) hi_q <= bus.wdata;
          if (bus.start) begin
            op_q  <= bus.op;
            rsign <= signed_op & (bus.a[W-1] ^ bus.b[W-1]);
            msign <= signed_op & bus.a[W-1];
            quick <= start_dz | start_fast;
            cnt   <= '0;
            if (start_dz || start_fast) begin
              opa <= bus.a;
              opb <= bus.b;
            end else begin
              opa <= a_mag;
              opb <= b_mag;
            end
            acc <= {{W{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
          end
        end
        RUN: begin
          acc <= op_q[1] ? div_step : mul_step;
          cnt <= cnt + 6'd1;
        end
        SIGN: begin
          lo_q <= res[W-1:0];
          hi_q <= res[2*W-1:W];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
// Latency: checks 33-cycle iterative timing and 1-cycle quick paths.
// Backpressure: checks that start/MT writes are ignored while busy.
module tb_mul_div_unit;
`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT  = 1;
  localparam int MUL_BUSY = 0;
`else
  localparam int MUL_LAT  = 33;
  localparam int MUL_BUSY = 33;
`endif

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  mul_div_unit_if #(.DATA_BITS(32)) bus ();

  mul_div_unit #(.DATA_BITS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  // Called just after a negedge: issues one request sampled at the next edge (E0), then
  // samples each following negedge. lat = k when done is seen after edge E_k, -1 on timeout.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int busy_cnt);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0;
    lat = -1;
    busy_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0;
    bus.mtlo = 1'b0; bus.mthi = 1'b0; bus.wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (bus.lo !== 32'h0) begin miscompares++; $display("FAIL reset_lo got %h want %h", bus.lo, 32'h0); end
    vectors++; if (bus.hi !== 32'h0) begin miscompares++; $display("FAIL reset_hi got %h want %h", bus.hi, 32'h0); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", bus.done); end
    rst = 1'b0;
  endtask

  task automatic test_mt_write();
    bus.mtlo = 1'b1; bus.wdata = 32'h1234;
    @(posedge clk);
    @(negedge clk);
    bus.mtlo = 1'b0; bus.mthi = 1'b1; bus.wdata = 32'hABCD;
    vectors++; if (bus.lo !== 32'h1234) begin miscompares++; $display("FAIL mtlo got %h want %h", bus.lo, 32'h1234); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL mtlo_done got %b want 0", bus.done); end
    @(posedge clk);
    @(negedge clk);
    bus.mthi = 1'b0; bus.wdata = '0;
    vectors++; if (bus.hi !== 32'hABCD) begin miscompares++; $display("FAIL mthi got %h want %h", bus.hi, 32'hABCD); end
    vectors++; if (bus.lo !== 32'h1234) begin miscompares++; $display("FAIL mthi_lo_kept got %h want %h", bus.lo, 32'h1234); end
  endtask

  task automatic test_multu();
    int lat, bc;
    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
    vectors++; if (lat !== MUL_LAT) begin miscompares++; $display("FAIL multu_latency got %0d want %0d", lat, MUL_LAT); end
    vectors++; if (bc !== MUL_BUSY) begin miscompares++; $display("FAIL multu_busy_cycles got %0d want %0d", bc, MUL_BUSY); end
    vectors++; if (bus.hi !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL multu_hi got %h want %h", bus.hi, 32'hFFFFFFFE); end
    vectors++; if (bus.lo !== 32'h00000001) begin miscompares++; $display("FAIL multu_lo got %h want %h", bus.lo, 32'h1); end
    @(posedge clk);
    @(negedge clk);
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL multu_done_drop got %b want 0", bus.done); end
  endtask

  task automatic test_mult_signed();
    int lat, bc;
    run_op(2'd0, 32'hFFFFFFFD, 32'd7, lat, bc);
    vectors++; if (lat !== MUL_LAT) begin miscompares++; $display("FAIL mult_latency got %0d want %0d", lat, MUL_LAT); end
    vectors++; if (bc !== MUL_BUSY) begin miscompares++; $display("FAIL mult_busy_cycles got %0d want %0d", bc, MUL_BUSY); end
    vectors++; if (bus.hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL mult_hi got %h want %h", bus.hi, 32'hFFFFFFFF); end
    vectors++; if (bus.lo !== 32'hFFFFFFEB) begin miscompares++; $display("FAIL mult_lo got %h want %h", bus.lo, 32'hFFFFFFEB); end
  endtask

  // Runs back to back: each new start is issued in the cycle done is high.
  task automatic test_divide();
    vec_t dv[4];
    int lat, bc;
    dv[0] = '{2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
    dv[1] = '{2'd3, 32'd100,      32'd7,        32'd14,       32'd2};
    dv[2] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0};
    dv[3] = '{2'd2, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
    for (int i = 0; i < 4; i++) begin
      run_op(dv[i].op, dv[i].a, dv[i].b, lat, bc);
      vectors++; if (lat !== 33) begin miscompares++; $display("FAIL div%0d_latency got %0d want 33", i, lat); end
      vectors++; if (bus.lo !== dv[i].lo) begin miscompares++; $display("FAIL div%0d_lo got %h want %h", i, bus.lo, dv[i].lo); end
      vectors++; if (bus.hi !== dv[i].hi) begin miscompares++; $display("FAIL div%0d_hi got %h want %h", i, bus.hi, dv[i].hi); end
    end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    run_op(2'd3, 32'd100, 32'd0, lat, bc);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL divu0_latency got %0d want 1", lat); end
    vectors++; if (bc !== 0) begin miscompares++; $display("FAIL divu0_busy got %0d want 0", bc); end
    vectors++; if (bus.lo !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL divu0_lo got %h want %h", bus.lo, 32'hFFFFFFFF); end
    vectors++; if (bus.hi !== 32'h64) begin miscompares++; $display("FAIL divu0_hi got %h want %h", bus.hi, 32'h64); end
    run_op(2'd2, 32'h80000000, 32'd0, lat, bc);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL div0_latency got %0d want 1", lat); end
    vectors++; if (bc !== 0) begin miscompares++; $display("FAIL div0_busy got %0d want 0", bc); end
    vectors++; if (bus.lo !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL div0_lo got %h want %h", bus.lo, 32'hFFFFFFFF); end
    vectors++; if (bus.hi !== 32'h80000000) begin miscompares++; $display("FAIL div0_hi got %h want %h", bus.hi, 32'h80000000); end
    @(posedge clk);
    @(negedge clk);
  endtask

  // MTLO together with start lands first, then the result overwrites it.
  task automatic test_mt_with_start();
    int lat, bc;
    bus.mtlo = 1'b1; bus.wdata = 32'h77;
    bus.start = 1'b1; bus.op = 2'd1; bus.a = 32'd2; bus.b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    bus.mtlo = 1'b0; bus.wdata = '0;
    bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0;
    vectors++; if (bus.lo !== 32'h77) begin miscompares++; $display("FAIL mt_start_lo got %h want %h", bus.lo, 32'h77); end
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      if (bus.done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    vectors++; if (lat !== MUL_LAT) begin miscompares++; $display("FAIL mt_start_latency got %0d want %0d", lat, MUL_LAT); end
    vectors++; if ({bus.hi, bus.lo} !== 64'd6) begin miscompares++; $display("FAIL mt_start_result got %h want %h", {bus.hi, bus.lo}, 64'd6); end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_ignore_busy();
    int lat = -1;
    bus.start = 1'b1; bus.op = 2'd2; bus.a = 32'd100; bus.b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0;
    for (int k = 0; k < 100; k++) begin
      if (k == 5) begin
        bus.start = 1'b1; bus.op = 2'd3; bus.a = 32'd1; bus.b = 32'd1;
        bus.mthi = 1'b1; bus.wdata = 32'h55;
      end else if (k == 6) begin
        bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0;
        bus.mthi = 1'b0; bus.wdata = '0;
      end
      if (bus.done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    vectors++; if (lat !== 33) begin miscompares++; $display("FAIL ignore_latency got %0d want 33", lat); end
    vectors++; if (bus.lo !== 32'd14) begin miscompares++; $display("FAIL ignore_lo got %h want %h", bus.lo, 32'd14); end
    vectors++; if (bus.hi !== 32'd2) begin miscompares++; $display("FAIL ignore_hi got %h want %h", bus.hi, 32'd2); end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int done_seen = 0;
    bus.start = 1'b1; bus.op = 2'd3; bus.a = 32'd50; bus.b = 32'd5;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (bus.lo !== 32'h0) begin miscompares++; $display("FAIL midrst_lo got %h want %h", bus.lo, 32'h0); end
    vectors++; if (bus.hi !== 32'h0) begin miscompares++; $display("FAIL midrst_hi got %h want %h", bus.hi, 32'h0); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
    for (int k = 0; k < 40; k++) begin
      if (bus.done) done_seen++;
      @(negedge clk);
    end
    vectors++; if (done_seen !== 0) begin miscompares++; $display("FAIL midrst_done got %0d pulses want 0", done_seen); end
    vectors++; if ({bus.hi, bus.lo} !== 64'h0) begin miscompares++; $display("FAIL midrst_lohi_after got %h want 0", {bus.hi, bus.lo}); end
  endtask

  initial begin
    test_reset();
    test_mt_write();
    test_multu();
    test_mult_signed();
    test_divide();
    test_div_zero();
    test_mt_with_start();
    test_ignore_busy();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
